// File: rtl/frame_pkg.sv
// Shared types and constants for the frame sequencer and its frame timer.
// State codes are plain localparams so older code can compare them directly.
package frame_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 3;

  localparam int DEF_SCREEN_W     = 160;
  localparam int DEF_SCREEN_H     = 120;
  localparam int DEF_FRAME_CYCLES = 833333;

  typedef logic [1:0] state_t;

  localparam state_t S_RESET = 2'd0;
  localparam state_t S_CLEAR = 2'd1;
  localparam state_t S_DRAW  = 2'd2;
  localparam state_t S_WAIT  = 2'd3;

  // True on the bottom-right pixel of a width x height sweep.
  function automatic logic sweep_last(input logic [COORD_W-1:0] cx,
                                      input logic [COORD_W-1:0] cy,
                                      input int                 width,
                                      input int                 height);
    return (cx == COORD_W'(width - 1)) && (cy == COORD_W'(height - 1));
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame timer: one registered frame_tick every FRAME_CYCLES clocks.
// Reusable on its own as the game-logic update strobe.
module frame_timer
  import frame_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  output logic frame_tick
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  // Down-counter: terminal count 0 fires the tick and reloads, so the first
  // tick lands right after reset releases.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      count      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (count == '0);
      if (count == '0) begin
        count <= CNT_W'(FRAME_CYCLES - 1);
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer between the draw controller and the VGA adapter:
// frame tick, background clear sweep, then a forwarded draw window.
//
// state   | meaning
// S_RESET | after reset, waiting for the first frame tick
// S_CLEAR | sweeping every pixel with BG_COLOR
// S_DRAW  | forwarding the draw controller's pixels until pass done
// S_WAIT  | frame finished, waiting for the next (or a pending) tick
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int                 SCREEN_W     = DEF_SCREEN_W,
  parameter int                 SCREEN_H     = DEF_SCREEN_H,
  parameter logic [COLOR_W-1:0] BG_COLOR     = '0,
  parameter int                 FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_plot,
  input  logic               in_pass_done,
  output logic               draw_enable,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               frame_tick,
  output logic               clear_busy,
  output logic               overrun
);

  state_t             state;
  state_t             state_nxt;
  logic [COORD_W-1:0] clr_x;
  logic [COORD_W-1:0] clr_y;
  logic               clr_last;
  logic               pending;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick)
  );

  assign clr_last = sweep_last(clr_x, clr_y, SCREEN_W, SCREEN_H);

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: if (frame_tick) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_last) state_nxt = S_DRAW;
      S_DRAW:  if (in_pass_done) state_nxt = S_WAIT;
      S_WAIT:  if (frame_tick || pending) state_nxt = S_CLEAR;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state   <= S_RESET;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      // A tick during clear/draw is remembered once; WAIT consumes it.
      if (state == S_WAIT) begin
        pending <= 1'b0;
      end else if (frame_tick && (state == S_CLEAR || state == S_DRAW)) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      clr_x <= '0;
      clr_y <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_x == COORD_W'(SCREEN_W - 1)) begin
        clr_x <= '0;
        clr_y <= (clr_y == COORD_W'(SCREEN_H - 1)) ? '0 : clr_y + 1'b1;
      end else begin
        clr_x <= clr_x + 1'b1;
      end
    end
  end

  // Output register: status flags are a one-cycle view of the state so they
  // line up with the pixels they describe.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      x           <= '0;
      y           <= '0;
      color       <= '0;
      plot        <= 1'b0;
      draw_enable <= 1'b0;
      clear_busy  <= 1'b0;
    end else begin
      draw_enable <= (state == S_DRAW);
      clear_busy  <= (state == S_CLEAR);
      case (state)
        S_CLEAR: begin
          x     <= clr_x;
          y     <= clr_y;
          color <= BG_COLOR;
          plot  <= 1'b1;
        end
        S_DRAW: begin
          x     <= in_x;
          y     <= in_y;
          color <= in_color;
          plot  <= in_plot;
        end
        default: plot <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed frame sequences, a forwarding vector
// table, and randomized traffic checked every cycle against a timeline model.
module tb_frame_sequencer;
  import frame_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FC = 40;
  localparam int WH = W * H;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] in_x = '0;
  logic [9:0] in_y = '0;
  logic [2:0] in_color = '0;
  logic       in_plot = 1'b0;
  logic       in_pass_done = 1'b0;
  logic       draw_enable;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] color;
  logic       plot;
  logic       frame_tick;
  logic       clear_busy;
  logic       overrun;

  always #5 clk = ~clk;

  frame_sequencer #(
    .SCREEN_W    (W),
    .SCREEN_H    (H),
    .BG_COLOR    (BG),
    .FRAME_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_color    (in_color),
    .in_plot     (in_plot),
    .in_pass_done(in_pass_done),
    .draw_enable (draw_enable),
    .x           (x),
    .y           (y),
    .color       (color),
    .plot        (plot),
    .frame_tick  (frame_tick),
    .clear_busy  (clear_busy),
    .overrun     (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: e = edge at which the clear state is entered, k = edge at
  // which pass done was accepted (-1 while the draw window is still open).
  int         n;
  int         e;
  int         k;
  bit         pend;
  bit         ovr;
  logic [9:0] mx;
  logic [9:0] my;
  logic [2:0] mc;

  always @(posedge clk) begin
    logic       r, pd, ip, ep, ede, ecb, etk;
    logic [9:0] ix, iy;
    logic [2:0] ic;
    bit         tprev, clearing, drawing, idle;
    int         ci;
    r = reset_n; pd = in_pass_done; ip = in_plot;
    ix = in_x; iy = in_y; ic = in_color;
    ep = 0; ede = 0; ecb = 0; etk = 0;
    if (r) begin
      n = 0; e = -1; k = -1; pend = 0; ovr = 0; mx = '0; my = '0; mc = '0;
    end else begin
      n++;
      etk      = ((n - 1) % FC == 0);
      tprev    = (n >= 2) && ((n - 2) % FC == 0);
      ci       = n - e - 1;
      clearing = (e >= 0) && (ci >= 0) && (ci < WH);
      drawing  = (e >= 0) && (n > e + WH) && (k < 0 || n <= k);
      idle     = (e < 0) || (k >= 0 && n > k);
      if (clearing) begin
        mx = 10'(ci % W); my = 10'(ci / W); mc = BG; ep = 1; ecb = 1;
      end else if (drawing) begin
        mx = ix; my = iy; mc = ic; ep = ip; ede = 1;
        if (pd) k = n;
      end
      if ((clearing || drawing) && tprev) begin
        pend = 1; ovr = 1;
      end
      if (idle && (pend || tprev)) begin
        e = n; k = -1; pend = 0;
      end
    end
    #1;
    chk("mon_x", x, mx);
    chk("mon_y", y, my);
    chk("mon_color", color, mc);
    chk("mon_plot", plot, ep);
    chk("mon_draw_enable", draw_enable, ede);
    chk("mon_clear_busy", clear_busy, ecb);
    chk("mon_frame_tick", frame_tick, etk);
    chk("mon_overrun", overrun, ovr);
  end

  typedef struct {
    logic [9:0] ix, iy;
    logic [2:0] ic;
    logic       ip;
    logic [9:0] ex, ey;
    logic [2:0] ec;
    logic       ep;
  } vec_t;

  vec_t vecs[6];

  task automatic check_startup();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("su_tick", frame_tick, c == 1);
      chk("su_busy", clear_busy, (c >= 3 && c <= 14));
      chk("su_plot", plot, (c >= 3 && c <= 14));
      chk("su_draw_enable", draw_enable, c >= 15);
      if (c >= 3 && c <= 14) begin
        chk("su_x", x, (c - 3) % W);
        chk("su_y", y, (c - 3) / W);
        chk("su_color", color, BG);
      end
    end
  endtask

  task automatic wait_tick(input string name);
    bit found = 0;
    for (int i = 0; i < 3 * FC && !found; i++) begin
      @(negedge clk);
      chk({name, "_draw_enable"}, draw_enable, 0);
      chk({name, "_gate_x"}, x == 10'd9, 0);
      if (frame_tick) found = 1;
    end
    if (!found) chk({name, "_tick_timeout"}, 0, 1);
  endtask

  initial begin
    bit found;
    vecs[0] = '{10'd5,    10'd7,    3'b101, 1'b1, 10'd5,    10'd7,    3'b101, 1'b1};
    vecs[1] = '{10'd5,    10'd7,    3'b101, 1'b0, 10'd5,    10'd7,    3'b101, 1'b0};
    vecs[2] = '{10'd0,    10'd0,    3'b111, 1'b1, 10'd0,    10'd0,    3'b111, 1'b1};
    vecs[3] = '{10'd1023, 10'd1023, 3'b010, 1'b1, 10'd1023, 10'd1023, 3'b010, 1'b1};
    vecs[4] = '{10'd159,  10'd119,  3'b001, 1'b1, 10'd159,  10'd119,  3'b001, 1'b1};
    vecs[5] = '{10'd600,  10'd3,    3'b100, 1'b0, 10'd600,  10'd3,    3'b100, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b0;
    check_startup();

    // Draw forwarding, one-cycle latency.
    foreach (vecs[i]) begin
      in_x = vecs[i].ix; in_y = vecs[i].iy; in_color = vecs[i].ic; in_plot = vecs[i].ip;
      @(negedge clk);
      chk("fwd_x", x, vecs[i].ex);
      chk("fwd_y", y, vecs[i].ey);
      chk("fwd_color", color, vecs[i].ec);
      chk("fwd_plot", plot, vecs[i].ep);
      chk("fwd_draw_enable", draw_enable, 1);
    end

    // Pass done with a simultaneous pixel.
    in_x = 10'd2; in_y = 10'd2; in_color = 3'b110; in_plot = 1'b1; in_pass_done = 1'b1;
    @(negedge clk);
    chk("pd_x", x, 2);
    chk("pd_y", y, 2);
    chk("pd_color", color, 3'b110);
    chk("pd_plot", plot, 1);
    in_pass_done = 1'b0; in_plot = 1'b0;
    @(negedge clk);
    chk("pd_draw_enable_off", draw_enable, 0);
    chk("pd_plot_off", plot, 0);

    // Gating: upstream pixels and pass done while waiting and clearing.
    in_x = 10'd9; in_color = 3'b111; in_plot = 1'b1; in_pass_done = 1'b1;
    wait_tick("gate");
    @(negedge clk);
    chk("gate_plot_wait", plot, 0);
    @(negedge clk);
    chk("gate_first_x", x, 0);
    chk("gate_first_y", y, 0);
    chk("gate_first_plot", plot, 1);
    for (int i = 1; i < WH; i++) begin
      @(negedge clk);
      chk("gate_clear_x", x == 10'd9, 0);
      chk("gate_clear_color", color, BG);
      chk("gate_clear_plot", plot, 1);
    end
    in_plot = 1'b0; in_pass_done = 1'b0; in_x = '0; in_color = '0;
    chk("ovr_before", overrun, 0);

    // Overrun: draw window still open when the next tick arrives.
    found = 0;
    for (int i = 0; i < 3 * FC && !found; i++) begin
      @(negedge clk);
      if (frame_tick) found = 1;
    end
    if (!found) chk("ovr_tick_timeout", 0, 1);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    in_pass_done = 1'b1;
    @(negedge clk);
    chk("ovr_last_draw", draw_enable, 1);
    in_pass_done = 1'b0;
    @(negedge clk);
    chk("ovr_wait_plot", plot, 0);
    chk("ovr_wait_busy", clear_busy, 0);
    @(negedge clk);
    chk("ovr_restart_plot", plot, 1);
    chk("ovr_restart_x", x, 0);
    chk("ovr_restart_y", y, 0);
    chk("ovr_restart_busy", clear_busy, 1);
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of the sweep at pixel 6.
    found = 0;
    for (int i = 0; i < 2 * WH && !found; i++) begin
      if (plot && x == 10'd2 && y == 10'd1) found = 1;
      else @(negedge clk);
    end
    if (!found) chk("mid_pixel6_timeout", 0, 1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_plot", plot, 0);
    chk("mid_busy", clear_busy, 0);
    chk("mid_overrun", overrun, 0);
    chk("mid_x", x, 0);
    reset_n = 1'b0;
    check_startup();

    // Randomized traffic, checked by the per-cycle model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset_n      = ($urandom_range(0, 399) == 0);
      in_x         = 10'($urandom_range(0, 1023));
      in_y         = 10'($urandom_range(0, 1023));
      in_color     = 3'($urandom_range(0, 7));
      in_plot      = 1'($urandom_range(0, 1));
      in_pass_done = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    reset_n = 1'b0;
    in_plot = 1'b0;
    in_pass_done = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Downstream stage of the draw controller, sitting between it and the VGA adapter. Each frame it generates the frame tick, sweeps the whole screen with the background colour, and then opens a draw window. During that window it forwards the draw controller's pixel stream to the adapter. It closes the window when the controller reports a complete entity pass.

## Interface
Parameters:
- SCREEN_W, 160, visible pixels per row
- SCREEN_H, 120, visible rows
- BG_COLOR, 3'b000, colour written by the clear sweep
- FRAME_CYCLES, 833333, clk cycles per frame (60 Hz at 50 MHz)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-high reset (asserted = 1)
- in_x  in  10  pixel x from draw controller
- in_y  in  10  pixel y from draw controller
- in_color  in  3  pixel colour from draw controller
- in_plot  in  1  pixel valid from draw controller
- in_pass_done  in  1  one-cycle pulse: draw controller finished all entities
- draw_enable  out  1  high only in S_DRAW; draw controller may emit pixels
- x  out  10  pixel x to VGA adapter
- y  out  10  pixel y to VGA adapter
- color  out  3  pixel colour to VGA adapter
- plot  out  1  write enable to VGA adapter
- frame_tick  out  1  one-cycle pulse at frame start (game-logic update strobe)
- clear_busy  out  1  high while the clear sweep runs
- overrun  out  1  sticky; a frame tick arrived before the previous frame finished

## Operation
- FSM states:
  - S_RESET: entered on reset. Leaves for S_CLEAR on the first frame_tick.
  - S_CLEAR: sweeps pixels, x inner 0..SCREEN_W-1, y outer 0..SCREEN_H-1. Drives one pixel per cycle with colour BG_COLOR and plot=1. After pixel (W-1,H-1) it moves to S_DRAW.
  - S_DRAW: draw_enable=1. Each cycle, in_x/in_y/in_color/in_plot are registered straight to x/y/color/plot. When in_pass_done=1 it moves to S_WAIT. A pixel arriving in the same cycle as in_pass_done is still forwarded.
  - S_WAIT: plot=0. On frame_tick, or if a tick is already pending, it moves to S_CLEAR.
- Input gating: in_plot is ignored in every state except S_DRAW. Outside S_DRAW, upstream pixels are dropped and never queued.
- Frame timer:
  - Free-running counter 0..FRAME_CYCLES-1; wraps to 0.
  - frame_tick=1 when the counter is 0, except during reset.
  - The counter never stalls for the FSM.
- Overrun handling (tick arriving in S_CLEAR or S_DRAW):
  - Sets the pending flag and sets overrun. overrun stays set until reset.
  - The current frame completes normally.
  - The pending flag is consumed when S_WAIT is entered: FSM spends 1 cycle in S_WAIT, then goes to S_CLEAR.
  - Multiple missed ticks collapse into one pending flag.
- Coordinates:
  - Clear counters are 10 bits and compare against SCREEN_W-1 and SCREEN_H-1 exactly.
  - Forwarded coordinates are passed unmodified. No clipping; out-of-range pixels are the adapter's concern.

## Timing
- Reset values: x=0, y=0, color=0, plot=0, draw_enable=0, frame_tick=0, clear_busy=0, overrun=0. Frame timer=0, pending=0, state S_RESET.
- frame_tick first pulses in the first cycle after reset_n deasserts. S_CLEAR starts the following cycle.
- Pipeline: one-cycle latency from in_* to x/y/color/plot in S_DRAW.
- Clear sweep:
  - First clear pixel (0,0) appears on outputs 1 cycle after entering S_CLEAR.
  - Sweep lasts exactly SCREEN_W*SCREEN_H cycles with plot continuously high.
- clear_busy is high for exactly those SCREEN_W*SCREEN_H cycles.
- draw_enable:
  - Rises the cycle after the last clear pixel.
  - Falls the cycle after in_pass_done is sampled high.
- reset_n mid-sweep or mid-draw: the next cycle shows plot=0 and all reset values. No partial pixel is emitted.
- in_pass_done outside S_DRAW is ignored.

## Structure
- Shared package frame_pkg holds:
  - state enum (S_RESET, S_CLEAR, S_DRAW, S_WAIT)
  - COORD_W=10, COLOR_W=3
  - default screen dimensions
- Sub-module frame_timer: FRAME_CYCLES counter plus frame_tick generation. Separately reusable by game logic.
- Top level holds the FSM, clear counters, pending/overrun flags and the output register mux.

## Test plan
Benches use SCREEN_W=4, SCREEN_H=3, FRAME_CYCLES=40.
- Reset release:
  - frame_tick high on cycle 1.
  - Cycles 3..14 show plot=1, color=000, and (x,y) sequence (0,0),(1,0)..(3,0),(0,1)..(3,2).
  - clear_busy high for exactly 12 cycles.
- Draw forwarding: in S_DRAW, drive in_x=5, in_y=7, in_color=3'b101, in_plot=1 -> next cycle x=5, y=7, color=101, plot=1. in_plot=0 -> plot=0.
- Gating: drive in_plot=1 with in_x=9 during S_CLEAR and S_WAIT -> output never shows x=9 with a non-BG colour. draw_enable=0 throughout.
- Pass done: in_pass_done with a simultaneous pixel (2,2,110) -> pixel forwarded, then draw_enable=0 and plot=0. Next clear starts 1 cycle after the cycle-40 tick.
- Overrun: hold in_pass_done low past tick 2 -> overrun=1. Pulse in_pass_done -> 1 cycle in S_WAIT, then clear starts without waiting for the next tick.
- Mid-sweep reset: assert reset_n at clear pixel 6 -> next cycle plot=0, clear_busy=0. After release, the sweep restarts at (0,0).
